gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctl: RTL and testbench
=======================================================

GF180MCU_FD_SC_MCU7T5V0__DFFRSNQ_CTL -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctl

Purpose: sequencer that drives the SETN/RN/D inputs of a set/reset flop bank and reads Q back against an expected value.

Interface
REQ-001 Parameter HOLD_CYC, default 2: number of cycles an asynchronous control stays asserted, legal range 1..255.
REQ-002 Parameter RECOV_CYC, default 2: number of cycles between control release and the Q sample, legal range 1..255.
REQ-003 Parameter CNT_W, default 8: width of the error counter.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 START  input  1  one-cycle pulse that launches one test sequence.
REQ-007 MODE  input  2  sequence select: 00 reset, 01 set, 10 both, 11 data.
REQ-008 D_IN  input  1  data value used in data mode.
REQ-009 Q_OBS  input  1  observed Q of the flop under test.
REQ-010 RN_O  output  1  active-low reset drive to the flop.
REQ-011 SETN_O  output  1  active-low set drive to the flop.
REQ-012 D_O  output  1  data drive to the flop.
REQ-013 BUSY  output  1  high while a sequence runs.
REQ-014 DONE  output  1  one-cycle pulse when a sequence ends.
REQ-015 PASS  output  1  result of the last compare, valid from DONE until the next START.
REQ-016 ERR_CNT  output  CNT_W  saturating count of failed compares.

Function
REQ-017 FSM states SHALL be IDLE, ASSERT, RELEASE, RECOV, CHECK; transitions are registered.
REQ-018 IDLE: RN_O=1, SETN_O=1, BUSY=0. START=1 latches MODE and D_IN and moves to ASSERT; START while BUSY=1 is ignored.
REQ-019 ASSERT: lasts exactly HOLD_CYC cycles.
- MODE 00: RN_O=0.
- MODE 01: SETN_O=0.
- MODE 10: both at 0.
- MODE 11: D_O=latched D_IN, controls inactive.
REQ-020 RELEASE: one cycle.
- MODE 10: SETN_O returns to 1 while RN_O stays 0.
- All other modes: every control returns to 1.
REQ-021 RECOV: all controls inactive; lasts exactly RECOV_CYC cycles.
REQ-022 CHECK: one cycle.
- Sample Q_OBS and compare against expected: 0 for MODE 00 and 10, 1 for MODE 01, latched D_IN for MODE 11.
- Assert DONE, register PASS, return to IDLE.
REQ-023 RN_O and SETN_O SHALL be direct register outputs, so no glitches reach the asynchronous pins.
REQ-024 Total latency from the START cycle to the DONE cycle SHALL be HOLD_CYC+RECOV_CYC+2 cycles.
REQ-025 A mismatch SHALL increment ERR_CNT by 1; at 2^CNT_W-1 the counter holds.
REQ-026 D_O SHALL hold its last driven value outside MODE 11.
REQ-027 START in the same cycle as DONE SHALL be ignored; a new sequence needs START while in IDLE.

Reset
REQ-028 RST=1 at a clock edge SHALL force, on the next cycle:
- state=IDLE, RN_O=0, SETN_O=1, D_O=0;
- BUSY=0, DONE=0, PASS=0, ERR_CNT=0.
REQ-029 RN_O SHALL go to 1 on the first edge after RST falls, with no START needed.
REQ-030 RST mid-sequence SHALL abort without a DONE pulse and without changing ERR_CNT before it clears.
REQ-031 RST SHALL take priority over START in the same cycle.

Verification
REQ-032 MODE=00, HOLD_CYC=2, RECOV_CYC=2, Q_OBS tracks a model flop:
- RN_O low for exactly 2 cycles;
- DONE 6 cycles after START;
- PASS=1, ERR_CNT=0.
REQ-033 MODE=01 with Q_OBS stuck at 0:
- SETN_O low for 2 cycles;
- PASS=0, ERR_CNT=1.
REQ-034 MODE=10:
- both controls low for 2 cycles;
- SETN_O rises one cycle before RN_O;
- expected Q=0, so Q_OBS=0 gives PASS=1.
REQ-035 MODE=11, D_IN=1, then D_IN=0 with a model flop:
- D_O follows each value;
- PASS=1 both times, ERR_CNT=0.
REQ-036 CNT_W=2 with 5 forced mismatches: ERR_CNT saturates at 3.
REQ-037 RST pulsed during ASSERT of MODE=01:
- SETN_O=1 and RN_O=0 the next cycle;
- no DONE pulse;
- ERR_CNT=0;
- a START after reset completes normally.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctl_if.sv
// Control and flop-drive bundle between a test controller (master) and the
// set/reset flop sequencer (slave).
interface gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctl_if #(
  parameter int CNT_W = 8
);
  logic             START;
  logic [1:0]       MODE;
  logic             D_IN;
  logic             Q_OBS;
  logic             RN_O;
  logic             SETN_O;
  logic             D_O;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [CNT_W-1:0] ERR_CNT;

  modport master (
    output START, MODE, D_IN, Q_OBS,
    input  RN_O, SETN_O, D_O, BUSY, DONE, PASS, ERR_CNT
  );

  modport slave (
    input  START, MODE, D_IN, Q_OBS,
    output RN_O, SETN_O, D_O, BUSY, DONE, PASS, ERR_CNT
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctl.sv
// Sequencer that exercises the SETN/RN/D pins of a set/reset flop and checks
// the resulting Q, keeping a saturating count of failed checks.
module gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctl #(
  parameter int HOLD_CYC  = 2,
  parameter int RECOV_CYC = 2,
  parameter int CNT_W     = 8
) (
  input  logic CLK,
  input  logic RST,
  gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ASSERT  = 3'd1,
    RELEASE = 3'd2,
    RECOV   = 3'd3,
    CHECK   = 3'd4
  } state_t;

  localparam logic [7:0]       HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [7:0]       RECOV_LD = 8'(RECOV_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           r_state, w_state_next;
  logic [7:0]       r_cnt, w_cnt_next;
  logic [1:0]       r_mode;
  logic             r_d;
  logic             r_rn, r_setn, r_d_o, r_busy, r_done, r_pass;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_rn_next, w_setn_next, w_d_o_next;
  logic             w_busy_next, w_done_next, w_pass_next, w_err_inc;
  logic             w_exp_q;
  logic [1:0]       w_mode_eff;
  logic             w_d_eff;

  // On the launching edge the latches are not yet loaded, so use the live inputs.
  assign w_mode_eff = (r_state == IDLE) ? bus.MODE : r_mode;
  assign w_d_eff    = (r_state == IDLE) ? bus.D_IN : r_d;

  always_comb begin
    w_exp_q = 1'b0;
    case (r_mode)
      2'b01:   w_exp_q = 1'b1;
      2'b11:   w_exp_q = r_d;
      default: w_exp_q = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pass_next  = r_pass;
    w_err_inc    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.START) begin
          w_state_next = ASSERT;
          w_cnt_next   = HOLD_LD;
        end
      end
      ASSERT: begin
        if (r_cnt == 8'd0) w_state_next = RELEASE;
        else               w_cnt_next   = r_cnt - 8'd1;
      end
      RELEASE: begin
        w_state_next = RECOV;
        w_cnt_next   = RECOV_LD;
      end
      RECOV: begin
        // Q is sampled on the edge into CHECK so PASS is valid alongside DONE.
        if (r_cnt == 8'd0) begin
          w_state_next = CHECK;
          w_pass_next  = (bus.Q_OBS == w_exp_q);
          w_err_inc    = (bus.Q_OBS != w_exp_q);
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      CHECK:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    w_rn_next   = 1'b1;
    w_setn_next = 1'b1;
    w_d_o_next  = r_d_o;
    case (w_state_next)
      ASSERT: begin
        case (w_mode_eff)
          2'b00: w_rn_next   = 1'b0;
          2'b01: w_setn_next = 1'b0;
          2'b10: begin
            w_rn_next   = 1'b0;
            w_setn_next = 1'b0;
          end
          default: w_d_o_next = w_d_eff;
        endcase
      end
      RELEASE: begin
        if (r_mode == 2'b10) w_rn_next = 1'b0;
      end
      default: ;
    endcase
    w_busy_next = (w_state_next != IDLE);
    w_done_next = (w_state_next == CHECK);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_mode  <= 2'b00;
      r_d     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (r_state == IDLE && bus.START) begin
        r_mode <= bus.MODE;
        r_d    <= bus.D_IN;
      end
    end
  end

  // Flop drives come straight from registers so the async pins never see glitches.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rn      <= 1'b0;
      r_setn    <= 1'b1;
      r_d_o     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_rn   <= w_rn_next;
      r_setn <= w_setn_next;
      r_d_o  <= w_d_o_next;
      r_busy <= w_busy_next;
      r_done <= w_done_next;
      r_pass <= w_pass_next;
      if (w_err_inc && r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.RN_O    = r_rn;
  assign bus.SETN_O  = r_setn;
  assign bus.D_O     = r_d_o;
  assign bus.BUSY    = r_busy;
  assign bus.DONE    = r_done;
  assign bus.PASS    = r_pass;
  assign bus.ERR_CNT = r_err_cnt;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctl.sv
// Scoreboard bench: a main sequencer drives a behavioural set/reset flop, a
// second narrow-counter instance sees a stuck-at-0 Q to exercise saturation.
module tb_gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctl_if #(.CNT_W(8)) bus_m ();
  gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctl_if #(.CNT_W(2)) bus_s ();

  gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctl #(.HOLD_CYC(2), .RECOV_CYC(2), .CNT_W(8)) u_dut (
    .CLK(clk), .RST(rst), .bus(bus_m)
  );
  gf180mcu_fd_sc_mcu7t5v0__dffrsnq_ctl #(.HOLD_CYC(1), .RECOV_CYC(3), .CNT_W(2)) u_sat (
    .CLK(clk), .RST(rst), .bus(bus_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural flop under test; its clock is gated so set/reset results persist.
  logic q_model     = 1'b0;
  logic flop_clk_en = 1'b0;
  logic force_en    = 1'b0;
  logic force_val   = 1'b0;
  always @(posedge clk or negedge bus_m.RN_O or negedge bus_m.SETN_O) begin
    if (!bus_m.RN_O)        q_model <= 1'b0;
    else if (!bus_m.SETN_O) q_model <= 1'b1;
    else if (flop_clk_en)   q_model <= bus_m.D_O;
  end
  assign bus_m.Q_OBS = force_en ? force_val : q_model;
  assign bus_s.Q_OBS = 1'b0;

  typedef struct packed {
    logic       pass;
    logic [7:0] err;
  } exp_t;
  exp_t       sb_q[$];
  exp_t       sb_e;
  logic [7:0] exp_err = 8'd0;

  always @(negedge clk) begin
    if (bus_m.DONE) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        $display("seq done: mode=%0d pass=%0d err_cnt=%0d (exp pass=%0d err_cnt=%0d)",
                 u_dut.r_mode, bus_m.PASS, bus_m.ERR_CNT, sb_e.pass, sb_e.err);
        chk("sb_pass", 32'(bus_m.PASS), 32'(sb_e.pass));
        chk("sb_err_cnt", 32'(bus_m.ERR_CNT), 32'(sb_e.err));
      end
    end
  end

  task automatic run_seq(input logic [1:0] mode, input logic d, input logic exp_pass,
                         input bit start_on_done,
                         output int rn_low, output int setn_low, output int both_low,
                         output int rn_last, output int setn_last, output int lat,
                         output logic d_assert, output logic d_end);
    rn_low = 0; setn_low = 0; both_low = 0; rn_last = 0; setn_last = 0; lat = 0;
    d_assert = 1'b0; d_end = 1'b0;
    if (!exp_pass && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    sb_q.push_back(exp_t'{exp_pass, exp_err});
    @(negedge clk);
    bus_m.START = 1'b1;
    bus_m.MODE  = mode;
    bus_m.D_IN  = d;
    @(negedge clk);
    bus_m.START = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (!bus_m.RN_O)   begin rn_low++;   rn_last = k;   end
      if (!bus_m.SETN_O) begin setn_low++; setn_last = k; end
      if (!bus_m.RN_O && !bus_m.SETN_O) both_low++;
      if (k == 1) d_assert = bus_m.D_O;
      if (bus_m.DONE) begin
        lat   = k;
        d_end = bus_m.D_O;
        if (start_on_done) bus_m.START = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus_m.START = 1'b0;
    if (start_on_done) chk("start_on_done_ignored", 32'(bus_m.BUSY), 32'd0);
  endtask

  int   rn_low, setn_low, both_low, rn_last, setn_last, lat;
  logic d_assert, d_end;
  int   done_seen;

  initial begin
    bus_m.START = 1'b0; bus_m.MODE = 2'b00; bus_m.D_IN = 1'b0;
    bus_s.START = 1'b0; bus_s.MODE = 2'b00; bus_s.D_IN = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rn",     32'(bus_m.RN_O),    32'd0);
    chk("rst_setn",   32'(bus_m.SETN_O),  32'd1);
    chk("rst_d_o",    32'(bus_m.D_O),     32'd0);
    chk("rst_busy",   32'(bus_m.BUSY),    32'd0);
    chk("rst_done",   32'(bus_m.DONE),    32'd0);
    chk("rst_pass",   32'(bus_m.PASS),    32'd0);
    chk("rst_err",    32'(bus_m.ERR_CNT), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rn_rise_after_rst", 32'(bus_m.RN_O), 32'd1);

    // Reset mode, Q from the model flop.
    run_seq(2'b00, 1'b0, 1'b1, 1'b0, rn_low, setn_low, both_low, rn_last, setn_last, lat, d_assert, d_end);
    chk("m00_rn_low",   32'(rn_low),   32'd2);
    chk("m00_setn_low", 32'(setn_low), 32'd0);
    chk("m00_latency",  32'(lat),      32'd6);

    // Both mode: SETN releases a cycle before RN, Q ends up 0.
    run_seq(2'b10, 1'b0, 1'b1, 1'b0, rn_low, setn_low, both_low, rn_last, setn_last, lat, d_assert, d_end);
    chk("m10_both_low",  32'(both_low),    32'd2);
    chk("m10_setn_low",  32'(setn_low),    32'd2);
    chk("m10_rise_order", 32'(rn_last),    32'(setn_last + 1));
    chk("m10_latency",   32'(lat),         32'd6);

    // Data mode, flop clock enabled so it captures D_O.
    flop_clk_en = 1'b1;
    run_seq(2'b11, 1'b1, 1'b1, 1'b0, rn_low, setn_low, both_low, rn_last, setn_last, lat, d_assert, d_end);
    chk("m11d1_d_assert", 32'(d_assert), 32'd1);
    chk("m11d1_d_hold",   32'(d_end),    32'd1);
    chk("m11d1_ctl_low",  32'(rn_low + setn_low), 32'd0);
    run_seq(2'b11, 1'b0, 1'b1, 1'b1, rn_low, setn_low, both_low, rn_last, setn_last, lat, d_assert, d_end);
    chk("m11d0_d_assert", 32'(d_assert), 32'd0);
    chk("m11d0_d_hold",   32'(d_end),    32'd0);
    chk("m11d0_latency",  32'(lat),      32'd6);
    flop_clk_en = 1'b0;

    // Set mode against a Q stuck at 0: mismatch expected.
    force_en = 1'b1; force_val = 1'b0;
    run_seq(2'b01, 1'b0, 1'b0, 1'b0, rn_low, setn_low, both_low, rn_last, setn_last, lat, d_assert, d_end);
    chk("m01_setn_low", 32'(setn_low), 32'd2);
    chk("m01_rn_low",   32'(rn_low),   32'd0);
    force_en = 1'b0;

    // Abort a set sequence with reset during ASSERT.
    @(negedge clk);
    bus_m.START = 1'b1; bus_m.MODE = 2'b01; bus_m.D_IN = 1'b0;
    @(negedge clk);
    bus_m.START = 1'b0;
    chk("abort_setn_in_assert", 32'(bus_m.SETN_O), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_setn", 32'(bus_m.SETN_O),  32'd1);
    chk("abort_rn",   32'(bus_m.RN_O),    32'd0);
    chk("abort_busy", 32'(bus_m.BUSY),    32'd0);
    chk("abort_err",  32'(bus_m.ERR_CNT), 32'd0);
    rst = 1'b0;
    exp_err = 8'd0;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus_m.DONE) done_seen++;
      if (k == 0) chk("abort_rn_recover", 32'(bus_m.RN_O), 32'd1);
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);

    // Reset wins over a simultaneous START.
    rst = 1'b1; bus_m.START = 1'b1; bus_m.MODE = 2'b00;
    @(negedge clk);
    rst = 1'b0; bus_m.START = 1'b0;
    @(negedge clk);
    chk("rst_over_start_busy", 32'(bus_m.BUSY), 32'd0);
    chk("rst_over_start_rn",   32'(bus_m.RN_O), 32'd1);

    run_seq(2'b01, 1'b0, 1'b1, 1'b0, rn_low, setn_low, both_low, rn_last, setn_last, lat, d_assert, d_end);
    chk("post_abort_latency", 32'(lat), 32'd6);

    // Narrow counter saturates at 3 after repeated mismatches.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_s.START = 1'b1; bus_s.MODE = 2'b01; bus_s.D_IN = 1'b0;
      @(negedge clk);
      bus_s.START = 1'b0;
      lat = 0; setn_low = 0;
      for (int k = 1; k <= 40; k++) begin
        if (!bus_s.SETN_O) setn_low++;
        if (bus_s.DONE) begin lat = k; break; end
        @(negedge clk);
      end
      $display("sat seq %0d: pass=%0d err_cnt=%0d latency=%0d", i, bus_s.PASS, bus_s.ERR_CNT, lat);
      chk("sat_latency",  32'(lat),           32'd6);
      chk("sat_setn_low", 32'(setn_low),      32'd1);
      chk("sat_pass",     32'(bus_s.PASS),    32'd0);
      chk("sat_err_cnt",  32'(bus_s.ERR_CNT), 32'((i + 1 > 3) ? 3 : i + 1));
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
